// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the four-way round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] to_onehot(input logic [1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between the four requesters and the arbiter.
interface mux4_rr_arbiter_if;
  import mux4_rr_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [1:0]       sel;
  logic             busy;
  logic             timeout;

  modport master (output req, input gnt, sel, busy, timeout);
  modport slave  (input req, output gnt, sel, busy, timeout);
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set req bit after 'last', wrapping.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last,
  output logic [1:0]       idx,
  output logic             vld
);

  logic [1:0] cand;

  // Walk from lowest to highest priority so the nearest requester after
  // 'last' overwrites everything else; offset 4 is 'last' itself.
  always_comb begin
    idx  = last;
    vld  = 1'b0;
    cand = last;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = last + 2'(i);
      if (req[cand]) begin
        idx = cand;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared mux4_1: registered one-hot grant, mux select,
// bounded hold time and a one-cycle idle bubble between owners.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  mux4_rr_arbiter_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  state_e            state;
  logic [N_REQ-1:0]  gnt_q;
  logic [1:0]        sel_q;
  logic              busy_q;
  logic              timeout_q;
  logic [HOLD_W-1:0] cnt;
  logic [1:0]        last;

  logic [1:0]        pick_idx;
  logic              pick_vld;

  rr_pick4 u_pick (
    .req  (bus.req),
    .last (last),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      gnt_q     <= '0;
      sel_q     <= 2'b00;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt       <= '0;
      last      <= 2'd3;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // sel is left alone while idle so the mux output does not move
          if (pick_vld) begin
            gnt_q  <= to_onehot(pick_idx);
            sel_q  <= pick_idx;
            busy_q <= 1'b1;
            cnt    <= '0;
            state  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Voluntary release takes precedence over the hold timeout
          if (!bus.req[sel_q]) begin
            gnt_q  <= '0;
            busy_q <= 1'b0;
            last   <= sel_q;
            state  <= ST_IDLE;
          end else if (MAX_HOLD != 0 && cnt == HOLD_LAST) begin
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            last      <= sel_q;
            timeout_q <= 1'b1;
            state     <= ST_IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: MAX_HOLD=8 main instance plus a
// MAX_HOLD=0 instance for the no-timeout case.
module tb_mux4_rr_arbiter;
  import mux4_rr_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter_if bus();
  mux4_rr_arbiter_if bus0();

  mux4_rr_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mux4_rr_arbiter #(.MAX_HOLD(0), .HOLD_W(4)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    bus.req  = '0;
    bus0.req = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.gnt, bus.sel, bus.busy, bus.timeout} !== 8'b0000_00_0_0) begin
      n_fail++;
      $display("FAIL reset_main: got gnt=%b sel=%b busy=%b to=%b, want 0000 00 0 0",
               bus.gnt, bus.sel, bus.busy, bus.timeout);
    end
    n_checks++;
    if ({bus0.gnt, bus0.sel, bus0.busy, bus0.timeout} !== 8'b0000_00_0_0) begin
      n_fail++;
      $display("FAIL reset_nohold: got gnt=%b sel=%b busy=%b to=%b, want 0000 00 0 0",
               bus0.gnt, bus0.sel, bus0.busy, bus0.timeout);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if ({bus.gnt, bus.sel, bus.busy, bus.timeout} !== 8'b0001_00_1_0) begin
        n_fail++;
        $display("FAIL single_grant[%0d]: got gnt=%b sel=%b busy=%b to=%b, want 0001 00 1 0",
                 k, bus.gnt, bus.sel, bus.busy, bus.timeout);
      end
    end
    bus.req = 4'b0000;
    step();
    n_checks++;
    if ({bus.gnt, bus.sel, bus.busy, bus.timeout} !== 8'b0000_00_0_0) begin
      n_fail++;
      $display("FAIL single_release: got gnt=%b sel=%b busy=%b to=%b, want 0000 00 0 0",
               bus.gnt, bus.sel, bus.busy, bus.timeout);
    end
  endtask

  task automatic test_rotate();
    logic [1:0] owner;
    logic [3:0] exp_gnt;
    do_reset();
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      owner   = 2'(g);
      exp_gnt = 4'b0001 << owner;
      for (int k = 0; k < 8; k++) begin
        step();
        n_checks++;
        if ({bus.gnt, bus.sel, bus.busy, bus.timeout} !== {exp_gnt, owner, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL rotate_grant[%0d.%0d]: got gnt=%b sel=%b busy=%b to=%b, want %b %b 1 0",
                   g, k, bus.gnt, bus.sel, bus.busy, bus.timeout, exp_gnt, owner);
        end
      end
      step();
      n_checks++;
      if ({bus.gnt, bus.sel, bus.busy, bus.timeout} !== {4'b0000, owner, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL rotate_bubble[%0d]: got gnt=%b sel=%b busy=%b to=%b, want 0000 %b 0 1",
                 g, bus.gnt, bus.sel, bus.busy, bus.timeout, owner);
      end
    end
    bus.req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_release_wins();
    do_reset();
    bus.req = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if ({bus.gnt, bus.sel, bus.busy, bus.timeout} !== 8'b0100_10_1_0) begin
        n_fail++;
        $display("FAIL tie_grant[%0d]: got gnt=%b sel=%b busy=%b to=%b, want 0100 10 1 0",
                 k, bus.gnt, bus.sel, bus.busy, bus.timeout);
      end
    end
    bus.req = 4'b0000;
    step();
    n_checks++;
    if ({bus.gnt, bus.sel, bus.busy, bus.timeout} !== 8'b0000_10_0_0) begin
      n_fail++;
      $display("FAIL tie_release: got gnt=%b sel=%b busy=%b to=%b, want 0000 10 0 0",
               bus.gnt, bus.sel, bus.busy, bus.timeout);
    end
    step();
    n_checks++;
    if (bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_no_timeout: got to=%b, want 0", bus.timeout);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req = 4'b0010;
    step();
    bus.req = 4'b0000;
    step();
    n_checks++;
    if ({bus.gnt, bus.sel, bus.busy} !== 7'b0000_01_0) begin
      n_fail++;
      $display("FAIL wrap_sel_hold: got gnt=%b sel=%b busy=%b, want 0000 01 0",
               bus.gnt, bus.sel, bus.busy);
    end
    bus.req = 4'b0011;
    step();
    n_checks++;
    if ({bus.gnt, bus.sel, bus.busy} !== 7'b0001_00_1) begin
      n_fail++;
      $display("FAIL wrap_winner: got gnt=%b sel=%b busy=%b, want 0001 00 1",
               bus.gnt, bus.sel, bus.busy);
    end
    bus.req = 4'b0000;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 4'b0100;
    step();
    n_checks++;
    if ({bus.gnt, bus.sel, bus.busy} !== 7'b0100_10_1) begin
      n_fail++;
      $display("FAIL async_pre: got gnt=%b sel=%b busy=%b, want 0100 10 1",
               bus.gnt, bus.sel, bus.busy);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.gnt, bus.sel, bus.busy, bus.timeout} !== 8'b0000_00_0_0) begin
      n_fail++;
      $display("FAIL async_clear: got gnt=%b sel=%b busy=%b to=%b, want 0000 00 0 0",
               bus.gnt, bus.sel, bus.busy, bus.timeout);
    end
    bus.req = 4'b1000;
    #1;
    reset = 1'b0;
    step();
    n_checks++;
    if ({bus.gnt, bus.sel, bus.busy} !== 7'b1000_11_1) begin
      n_fail++;
      $display("FAIL async_regrant: got gnt=%b sel=%b busy=%b, want 1000 11 1",
               bus.gnt, bus.sel, bus.busy);
    end
    bus.req = 4'b0000;
    step();
  endtask

  task automatic test_no_hold();
    do_reset();
    bus0.req = 4'b0010;
    for (int k = 0; k < 40; k++) begin
      step();
      n_checks++;
      if ({bus0.gnt, bus0.sel, bus0.busy, bus0.timeout} !== 8'b0010_01_1_0) begin
        n_fail++;
        $display("FAIL nohold[%0d]: got gnt=%b sel=%b busy=%b to=%b, want 0010 01 1 0",
                 k, bus0.gnt, bus0.sel, bus0.busy, bus0.timeout);
      end
    end
    bus0.req = 4'b0000;
    step();
    n_checks++;
    if ({bus0.gnt, bus0.busy, bus0.timeout} !== 6'b0000_0_0) begin
      n_fail++;
      $display("FAIL nohold_release: got gnt=%b busy=%b to=%b, want 0000 0 0",
               bus0.gnt, bus0.busy, bus0.timeout);
    end
  endtask

  initial begin
    reset    = 1'b1;
    bus.req  = '0;
    bus0.req = '0;
    test_reset();
    test_single();
    test_rotate();
    test_release_wins();
    test_wrap();
    test_async_reset();
    test_no_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
